wb_trace_buffer: RTL and testbench

Writeback trace capture for the single-cycle processor. Sits beside the processor's register-file write port, records each retired register write (PC, destination register, data) into an on-chip FIFO, and lets a debug reader or testbench drain it at its own pace. It is the observing end of the processor's writeback interface, complementing the stimulus side that drives `clk`/`reset`.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/wb_trace_buffer_if.sv | 28 ++
 rtl/trace_fifo.sv | 55 +++++
 rtl/wb_trace_buffer.sv | 116 +++++++++++
 tb/tb_wb_trace_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types for the writeback trace buffer.
// Trigger types are used only when TRACE_TRIGGER_EN is defined.
package trace_pkg;

  localparam int DROP_W = 16;
  localparam int TRACE_PC_W = 32;
  localparam int TRACE_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    FROZEN
  } trig_state_t;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [4:0]              rd;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Writeback capture and reader drain signals of the trace buffer.
// The master side is the processor/reader, the slave side the buffer.
interface wb_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);

  logic              wb_valid;
  logic [PC_W-1:0]   wb_pc;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              rd_en;
  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [4:0]        rd_reg;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wb_valid, wb_pc, wb_rd, wb_data, rd_en,
    input  rd_valid, rd_pc, rd_reg, rd_data
  );

  modport slave (
    input  wb_valid, wb_pc, wb_rd, wb_data, rd_en,
    output rd_valid, rd_pc, rd_reg, rd_data
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO with simultaneous push/pop.
// Pointers carry an extension bit to tell full from empty.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 69
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  // a pop on a full FIFO frees the slot the push lands in
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= din;
  end

  assign dout = mem[rptr[AW-1:0]];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: filters x0 writes, counts drops.
// Optional trigger FSM enabled by defining TRACE_TRIGGER_EN.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
`ifdef TRACE_TRIGGER_EN
  ,
  parameter int POST_CNT = 8
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_trace_buffer_if.slave       bus,
  input  logic                   clr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
`ifdef TRACE_TRIGGER_EN
  ,
  input  logic                   trig_arm,
  input  logic [PC_W-1:0]        trig_pc,
  output logic                   triggered
`endif
);

  localparam int EW = PC_W + 5 + DATA_W;

  logic          cap;
  logic          cap_en;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [EW-1:0] head;

  assign cap = bus.wb_valid && (bus.wb_rd != 5'd0);

`ifdef TRACE_TRIGGER_EN
  trig_state_t state;
  logic [7:0]  pcnt;

  assign cap_en    = cap && (state != FROZEN);
  assign triggered = (state == FROZEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pcnt  <= '0;
    end else if (clr) begin
      state <= IDLE;
      pcnt  <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (trig_arm) state <= ARMED;
        ARMED:
          if (cap && bus.wb_pc == trig_pc) begin
            state <= POST;
            pcnt  <= 8'(POST_CNT);
          end
        // dropped captures still consume the post window
        POST:
          if (cap) begin
            pcnt <= pcnt - 1'b1;
            if (pcnt == 8'd1) state <= FROZEN;
          end
        FROZEN: ;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign cap_en = cap;
`endif

  assign pop  = bus.rd_en & ~empty;
  assign drop = cap_en & full & ~pop;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clr   (clr),
    .push  (cap_en),
    .pop   (pop),
    .din   ({bus.wb_pc, bus.wb_rd, bus.wb_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.rd_valid = ~empty;
  assign bus.rd_pc    = empty ? '0 : head[EW-1 -: PC_W];
  assign bus.rd_reg   = empty ? '0 : head[DATA_W +: 5];
  assign bus.rd_data  = empty ? '0 : head[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=8).
// Trigger scenario runs only when TRACE_TRIGGER_EN is defined.
module tb_wb_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;
`ifdef TRACE_TRIGGER_EN
  logic          trig_arm;
  logic [31:0]   trig_pc;
  logic          triggered;
`endif

  int vecs = 0;
  int errs = 0;

  wb_trace_buffer_if #(.PC_W(32), .DATA_W(32)) bus ();

  wb_trace_buffer #(
    .DEPTH  (DEPTH),
    .PC_W   (32),
    .DATA_W (32)
`ifdef TRACE_TRIGGER_EN
    ,
    .POST_CNT (2)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .clr      (clr),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
`ifdef TRACE_TRIGGER_EN
    ,
    .trig_arm  (trig_arm),
    .trig_pc   (trig_pc),
    .triggered (triggered)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [4:0] rd, input logic [31:0] d,
                     input logic pop);
    bus.wb_valid = v;
    bus.wb_pc    = pc;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
    bus.rd_en    = pop;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clr = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_pc = '0;
    bus.wb_rd = '0;
    bus.wb_data = '0;
    bus.rd_en = 1'b0;
`ifdef TRACE_TRIGGER_EN
    trig_arm = 1'b0;
    trig_pc = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vecs++;
    if ({count, overflow, drop_cnt} !== '0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d/%0b/%0d want 0/0/0",
               count, overflow, drop_cnt);
    end
    vecs++;
    if ({bus.rd_valid, bus.rd_pc, bus.rd_reg, bus.rd_data} !== '0) begin
      errs++;
      $display("FAIL reset_rd: got v=%0b pc=%0h want 0", bus.rd_valid, bus.rd_pc);
    end
  endtask

  task automatic test_basic;
    trace_entry_t e [3];
    e[0] = '{pc: 32'h00, rd: 5'd1, data: 32'hA};
    e[1] = '{pc: 32'h04, rd: 5'd2, data: 32'hB};
    e[2] = '{pc: 32'h08, rd: 5'd3, data: 32'hC};
    for (int i = 0; i < 3; i++) cyc(1'b1, e[i].pc, e[i].rd, e[i].data, 1'b0);
    vecs++;
    if (count !== CW'(3)) begin
      errs++;
      $display("FAIL basic_count: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({bus.rd_valid, bus.rd_pc, bus.rd_reg, bus.rd_data} !== {1'b1, e[i]}) begin
        errs++;
        $display("FAIL basic_head%0d: got pc=%0h rd=%0d d=%0h want pc=%0h rd=%0d d=%0h",
                 i, bus.rd_pc, bus.rd_reg, bus.rd_data, e[i].pc, e[i].rd, e[i].data);
      end
      cyc(1'b0, '0, '0, '0, 1'b1);
      vecs++;
      if (count !== CW'(2 - i)) begin
        errs++;
        $display("FAIL basic_pop%0d: got %0d want %0d", i, count, 2 - i);
      end
    end
    vecs++;
    if ({bus.rd_valid, bus.rd_pc, bus.rd_reg, bus.rd_data} !== '0) begin
      errs++;
      $display("FAIL basic_empty: got v=%0b pc=%0h d=%0h want 0",
               bus.rd_valid, bus.rd_pc, bus.rd_data);
    end
  endtask

  task automatic test_x0;
    cyc(1'b1, 32'h0C, 5'd0, 32'hFFFF, 1'b0);
    vecs++;
    if ({count, drop_cnt} !== '0) begin
      errs++;
      $display("FAIL x0_filter: got cnt=%0d drop=%0d want 0/0", count, drop_cnt);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b1, 32'(i * 4), 5'(i + 1), 32'h100 + 32'(i), 1'b0);
    vecs++;
    if ({count, overflow, drop_cnt} !== {CW'(DEPTH), 1'b1, 16'd2}) begin
      errs++;
      $display("FAIL ovf_state: got %0d/%0b/%0d want %0d/1/2",
               count, overflow, drop_cnt, DEPTH);
    end
    cyc(1'b1, 32'h80, 5'd7, 32'h55, 1'b1);
    vecs++;
    if ({count, drop_cnt} !== {CW'(DEPTH), 16'd2}) begin
      errs++;
      $display("FAIL ovf_pushpop: got %0d/%0d want %0d/2", count, drop_cnt, DEPTH);
    end
    vecs++;
    if ({bus.rd_pc, bus.rd_reg, bus.rd_data} !== {32'h4, 5'd2, 32'h101}) begin
      errs++;
      $display("FAIL ovf_head: got pc=%0h rd=%0d d=%0h want 4/2/101",
               bus.rd_pc, bus.rd_reg, bus.rd_data);
    end
    repeat (DEPTH - 1) cyc(1'b0, '0, '0, '0, 1'b1);
    vecs++;
    if ({count, bus.rd_valid, bus.rd_pc, bus.rd_reg, bus.rd_data} !==
        {CW'(1), 1'b1, 32'h80, 5'd7, 32'h55}) begin
      errs++;
      $display("FAIL ovf_tail: got cnt=%0d pc=%0h d=%0h want 1/80/55",
               count, bus.rd_pc, bus.rd_data);
    end
    cyc(1'b0, '0, '0, '0, 1'b1);
    vecs++;
    if ({count, bus.rd_valid, overflow} !== {CW'(0), 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL ovf_drain: got cnt=%0d v=%0b ovf=%0b want 0/0/1",
               count, bus.rd_valid, overflow);
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 32'h20, 5'd4, 32'h44, 1'b1);
    vecs++;
    if ({count, bus.rd_valid, bus.rd_pc, bus.rd_reg, bus.rd_data} !==
        {CW'(1), 1'b1, 32'h20, 5'd4, 32'h44}) begin
      errs++;
      $display("FAIL empty_pushpop: got cnt=%0d pc=%0h d=%0h want 1/20/44",
               count, bus.rd_pc, bus.rd_data);
    end
    clr = 1'b1;
    cyc(1'b1, 32'h24, 5'd5, 32'h45, 1'b1);
    clr = 1'b0;
    vecs++;
    if ({count, overflow, drop_cnt, bus.rd_valid} !== '0) begin
      errs++;
      $display("FAIL clr: got cnt=%0d ovf=%0b drop=%0d v=%0b want 0",
               count, overflow, drop_cnt, bus.rd_valid);
    end
  endtask

`ifdef TRACE_TRIGGER_EN
  task automatic test_trigger;
    trig_pc = 32'h10;
    trig_arm = 1'b1;
    cyc(1'b0, '0, '0, '0, 1'b0);
    trig_arm = 1'b0;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h0C + 32'(i * 4), 5'(i + 1), 32'(i), 1'b0);
    vecs++;
    if ({count, triggered, drop_cnt} !== {CW'(4), 1'b1, 16'd0}) begin
      errs++;
      $display("FAIL trig_state: got cnt=%0d trg=%0b drop=%0d want 4/1/0",
               count, triggered, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (bus.rd_pc !== 32'h0C + 32'(i * 4)) begin
        errs++;
        $display("FAIL trig_head%0d: got %0h want %0h", i, bus.rd_pc, 32'h0C + i * 4);
      end
      cyc(1'b0, '0, '0, '0, 1'b1);
    end
    clr = 1'b1;
    cyc(1'b0, '0, '0, '0, 1'b0);
    clr = 1'b0;
    vecs++;
    if ({triggered, count} !== '0) begin
      errs++;
      $display("FAIL trig_clr: got trg=%0b cnt=%0d want 0/0", triggered, count);
    end
  endtask
`endif

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h200 + 32'(i * 4), 5'(i + 10), 32'h300 + 32'(i), 1'b0);
    vecs++;
    if (count !== CW'(5)) begin
      errs++;
      $display("FAIL arst_fill: got %0d want 5", count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++;
    if ({count, overflow, drop_cnt, bus.rd_valid, bus.rd_pc, bus.rd_reg, bus.rd_data} !== '0) begin
      errs++;
      $display("FAIL arst_clear: got cnt=%0d v=%0b pc=%0h want 0",
               count, bus.rd_valid, bus.rd_pc);
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'h40, 5'd9, 32'h99, 1'b0);
    vecs++;
    if ({count, bus.rd_pc, bus.rd_reg, bus.rd_data} !== {CW'(1), 32'h40, 5'd9, 32'h99}) begin
      errs++;
      $display("FAIL arst_sole: got cnt=%0d pc=%0h d=%0h want 1/40/99",
               count, bus.rd_pc, bus.rd_data);
    end
    cyc(1'b0, '0, '0, '0, 1'b1);
    vecs++;
    if ({count, bus.rd_valid} !== '0) begin
      errs++;
      $display("FAIL arst_drain: got cnt=%0d v=%0b want 0/0", count, bus.rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_overflow();
    test_back_to_back();
`ifdef TRACE_TRIGGER_EN
    test_trigger();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
